// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit, registered back-pressured result.
// Optional operation counter port enabled by LOGIC_ARB_PERF_EN.
module logic_unit_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 32,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*2-1:0]     req_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id
`ifdef LOGIC_ARB_PERF_EN
    ,
    output logic [15:0]            grant_count
`endif
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  r_ptr;

    logic             w_found;
    logic [ID_W-1:0]  w_win;
    logic             w_slot_free;
    logic             w_accept;
    logic [N_REQ-1:0] w_ready;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_res;
    logic [ID_W-1:0]  w_ptr_nxt;

    // Search from the pointer upward, wrapping, first valid wins.
    always_comb begin : p_arb
        int v_idx;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= N_REQ) begin
                v_idx = v_idx - N_REQ;
            end
            if (!w_found && req_valid[v_idx]) begin
                w_found = 1'b1;
                w_win   = ID_W'(v_idx);
            end
        end
    end

    assign w_slot_free = (r_state == S_EMPTY) || rsp_ready;
    // Gating with reset_n keeps req_ready low while reset is held.
    assign w_accept    = reset_n && w_found && w_slot_free;

    always_comb begin
        w_ready = '0;
        if (w_accept) begin
            w_ready[w_win] = 1'b1;
        end
    end

    assign req_ready = w_ready;

    assign w_a  = req_a[int'(w_win)*WIDTH +: WIDTH];
    assign w_b  = req_b[int'(w_win)*WIDTH +: WIDTH];
    assign w_op = req_op[int'(w_win)*2 +: 2];

    always_comb begin
        w_res = '0;
        unique case (w_op)
            2'b00: w_res = w_a & w_b;
            2'b01: w_res = w_a | w_b;
            2'b10: w_res = w_a ^ w_b;
            2'b11: w_res = ~(w_a | w_b);
        endcase
    end

    assign w_ptr_nxt = (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = S_FULL;
        end else if (r_state == S_FULL && rsp_ready) begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
            r_id   <= '0;
            r_ptr  <= '0;
        end else if (w_accept) begin
            r_data <= w_res;
            r_id   <= w_win;
            r_ptr  <= w_ptr_nxt;
        end
    end

    assign rsp_valid = (r_state == S_FULL);
    assign rsp_data  = r_data;
    assign rsp_id    = r_id;

`ifdef LOGIC_ARB_PERF_EN
    logic [15:0] r_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_accept && r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign grant_count = r_cnt;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter (N_REQ=4, WIDTH=32).
module tb_logic_unit_arbiter;

    logic         clock;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [7:0]   req_op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;
`ifdef LOGIC_ARB_PERF_EN
    logic [15:0]  grant_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_res [4];

    logic_unit_arbiter #(
        .N_REQ(4),
        .WIDTH(32)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef LOGIC_ARB_PERF_EN
        ,
        .grant_count (grant_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        exp_res[0] = 32'h0A0A_5050;
        exp_res[1] = 32'hAFAF_F5F5;
        exp_res[2] = 32'hA5A5_A5A5;
        exp_res[3] = 32'h5050_0A0A;

        reset_n   = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        #12;
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_id", {30'b0, rsp_id}, 32'd0);
        chk("reset_req_ready", {28'b0, req_ready}, 32'd0);
`ifdef LOGIC_ARB_PERF_EN
        chk("reset_grant_count", {16'b0, grant_count}, 32'd0);
`endif

        // Single AND from requester 2
        #5;
        reset_n         = 1'b1;
        req_valid       = 4'b0100;
        req_a[64 +: 32] = 32'hF0F0_F0F0;
        req_b[64 +: 32] = 32'hFF00_FF00;
        req_op[5:4]     = 2'b00;
        #1;
        chk("t1_ready", {28'b0, req_ready}, 32'h4);
        tick();
        chk("t1_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t1_data", rsp_data, 32'hF000_F000);
        chk("t1_id", {30'b0, rsp_id}, 32'd2);
`ifdef LOGIC_ARB_PERF_EN
        chk("t1_grant_count", {16'b0, grant_count}, 32'd1);
`endif

        // Idle drain: data/id hold, pointer stays at 3
        req_valid = 4'b0000;
        #1;
        chk("idle_ready", {28'b0, req_ready}, 32'h0);
        tick();
        chk("drain_valid", {31'b0, rsp_valid}, 32'd0);
        chk("drain_data", rsp_data, 32'hF000_F000);
        chk("drain_id", {30'b0, rsp_id}, 32'd2);

        req_valid = 4'b1001;
        #1;
        chk("ptr3_ready", {28'b0, req_ready}, 32'h8);
        tick();
        chk("ptr3_id", {30'b0, rsp_id}, 32'd3);
        chk("ptr3_valid", {31'b0, rsp_valid}, 32'd1);

        // All valid, opcode sweep: requester i uses opcode i
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = 32'hAAAA_5555;
            req_b[i*32 +: 32] = 32'h0F0F_F0F0;
            req_op[i*2 +: 2]  = 2'(i);
        end
        req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk($sformatf("rr_ready_%0d", j), {28'b0, req_ready},
                32'(1 << (j % 4)));
            tick();
            chk($sformatf("rr_id_%0d", j), {30'b0, rsp_id}, 32'(j % 4));
            chk($sformatf("rr_data_%0d", j), rsp_data, exp_res[j % 4]);
        end

        // Back-pressure for 3 cycles while holding requester 0's AND result
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk($sformatf("bp_ready_%0d", j), {28'b0, req_ready}, 32'h0);
            tick();
            chk($sformatf("bp_valid_%0d", j), {31'b0, rsp_valid}, 32'd1);
            chk($sformatf("bp_id_%0d", j), {30'b0, rsp_id}, 32'd0);
            chk($sformatf("bp_data_%0d", j), rsp_data, exp_res[0]);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {28'b0, req_ready}, 32'h2);
        tick();
        chk("bp_release_id", {30'b0, rsp_id}, 32'd1);
        chk("bp_release_data", rsp_data, exp_res[1]);

        // Async reset mid-operation; pointer would otherwise pick 3
        rsp_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        chk("mid_rst_id", {30'b0, rsp_id}, 32'd0);
        chk("mid_rst_ready", {28'b0, req_ready}, 32'h0);
        #3;
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("post_rst_ready", {28'b0, req_ready}, 32'h2);
        tick();
        chk("post_rst_id", {30'b0, rsp_id}, 32'd1);
        chk("post_rst_valid", {31'b0, rsp_valid}, 32'd1);

`ifdef LOGIC_ARB_PERF_EN
        req_valid = 4'b1111;
        repeat (70000) tick();
        chk("cnt_saturate", {16'b0, grant_count}, 32'h0000_FFFF);
        #2;
        reset_n = 1'b0;
        #1;
        chk("cnt_reset", {16'b0, grant_count}, 32'd0);
        reset_n = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
